z80_dma_master: RTL and testbench
=================================

Name: z80_dma_master

Overview:
- Bus-master stage that sits directly upstream of the Z80 system bus arbiter.
- Requests the bus via nBUSRQ and waits for nBUSAK.
- Copies a block of bytes memory-to-memory using Z80-style nRD/nWR cycles on shared tristate ADDR/DQ.
- Releases the bus when the block is finished.

Parameters:
- LEN_W, 16, width of length/counter
- RD_WAIT, 0, extra nRD-low cycles (wait states) per read
- WR_WAIT, 0, extra nWR-low cycles per write

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  one-cycle pulse; loads src/dst/len when idle
- src_addr  input  16  first source address
- dst_addr  input  16  first destination address
- length  input  LEN_W  byte count
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse at completion
- nBUSRQ  output  1  bus request, active low
- nBUSAK  input  1  bus acknowledge, active low
- nRD  inout  1  driven only while bus owned, else z
- nWR  inout  1  driven only while bus owned, else z
- ADDR  inout  16  driven only while bus owned, else z
- DQ  inout  8  driven only during write cycle, else z

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset: nBUSRQ=1, busy=0, done=0; nRD, nWR, ADDR, DQ all z; state IDLE.
- Reset mid-transfer: bus released on that same edge, with no completion pulse.
- start is ignored while busy.
- length=0: done pulses the cycle after start; busy stays 0; nBUSRQ never asserted.
- States: IDLE, REQ, RD_T1, RD_T2, RD_T3, WR_T1, WR_T2, WR_T3, REL.
- IDLE -> REQ on start: latch src/dst/count, busy=1, nBUSRQ=0.
- REQ: wait until nBUSAK==0 is sampled, for any number of cycles; then go to RD_T1.
- RD_T1 (1 cycle): drive ADDR=src, nRD=1, nWR=1.
- RD_T2 (1+RD_WAIT cycles): nRD=0. DQ is latched into the data register on the last RD_T2 edge.
- RD_T3 (1 cycle): nRD=1; ADDR still driven.
- WR_T1 (1 cycle): ADDR=dst, DQ=data register, nWR=1.
- WR_T2 (1+WR_WAIT cycles): nWR=0.
- WR_T3 (1 cycle): nWR=1; DQ held for data hold time. Then: src+=1, dst+=1, count-=1.
- If the new count != 0 -> RD_T1; else -> REL.
- REL (1 cycle): all bus outputs z, nBUSRQ=1, done=1, busy=0 next cycle; then -> IDLE.
- Byte timing: per-byte latency is 6+RD_WAIT+WR_WAIT cycles.
- Total cycles from start to done = 1 (REQ min) + N*(6+RD_WAIT+WR_WAIT) + 1 with immediate ack.
- Addresses wrap modulo 2^16 (0xFFFF+1 = 0x0000); no error.
- nRD and nWR are never low simultaneously; DQ is never driven while nRD=0.
- nBUSAK is only sampled in REQ; deassertion during a transfer is ignored.

Optional Feature:
- Macro: Z80_DMA_CYCLE_STEAL_EN.
- Defined: after each byte's WR_T3, go to REL-like state STEAL: bus z, nBUSRQ=1 for exactly one cycle, no done. Then re-enter REQ if count != 0; done only after the last byte.
- Undefined: burst mode as above, bus held for the whole block.

Decomposition:
- Package z80_bus_pkg holds:
  - state enum
  - TRUE/FALSE constants
  - ADDR_W=16, DATA_W=8
- Natural sub-module z80_bus_cycle: runs one T1/T2/T3 read or write cycle with wait states, owns the tristate drivers, and returns cycle_done plus read data. z80_dma_master holds the FSM sequencing REQ/REL and the counters.

Test Plan:
- Defaults, src=0x1000, dst=0x2000, len=3, memory 0x1000..2 = AA,55,C3, nBUSAK tied to nBUSRQ one cycle late -> 0x2000..2 = AA,55,C3; done exactly 21 cycles after start; nBUSRQ=1 and all bus lines z afterward.
- len=0 -> done pulse next cycle, nBUSRQ stays 1, ADDR stays z.
- Arbiter holds nBUSAK=1 for 10 cycles -> ADDR stays z and nRD/nWR stay z until the ack; the transfer then completes correctly.
- src=0xFFFF, len=2 -> reads from 0xFFFF then 0x0000.
- RD_WAIT=2, WR_WAIT=1 -> nRD low 3 cycles, nWR low 2 cycles; assertion checks nRD/nWR never both low.
- reset asserted during WR_T2 of byte 2 -> next edge: all bus lines z, nBUSRQ=1, busy=0, no done; a new start then works normally.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 DMA bus master: FSM state encoding,
// bus widths and boolean constants.
package z80_bus_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [3:0] {
      IDLE,
      REQ,
      RD_T1,
      RD_T2,
      RD_T3,
      WR_T1,
      WR_T2,
      WR_T3,
      REL,
      STEAL
   } state_t;

endpackage

// File: rtl/z80_bus_cycle.sv
// One Z80 read or write machine cycle (T1/T2/T3 with wait states in T2).
// Owns the tristate drivers and the byte data register.
module z80_bus_cycle
   import z80_bus_pkg::*;
#(
   parameter int RD_WAIT = 0,
   parameter int WR_WAIT = 0
) (
   input  logic              clock,
   input  state_t            state,
   input  logic [ADDR_W-1:0] addr,
   output logic              phase_end,
   output logic              cycle_done,
   output logic [DATA_W-1:0] rdata,
   inout  wire               nRD,
   inout  wire               nWR,
   inout  wire  [ADDR_W-1:0] ADDR,
   inout  wire  [DATA_W-1:0] DQ
);

   localparam int WAIT_W = 8;

   logic [WAIT_W-1:0] wait_cnt;
   logic              own;
   logic              wr_phase;

   always_comb begin
      own        = state inside {RD_T1, RD_T2, RD_T3, WR_T1, WR_T2, WR_T3};
      wr_phase   = state inside {WR_T1, WR_T2, WR_T3};
      phase_end  = TRUE;
      if (state == RD_T2 || state == WR_T2)
         phase_end = (wait_cnt == '0);
      cycle_done = phase_end && (state == RD_T3 || state == WR_T3);
   end

   // T1 arms the wait counter; T2 runs until it drains, the read sample lands on T2's final edge
   always_ff @(posedge clock) begin
      case (state)
         RD_T1:        wait_cnt <= WAIT_W'(RD_WAIT);
         WR_T1:        wait_cnt <= WAIT_W'(WR_WAIT);
         RD_T2, WR_T2: if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
         default:      wait_cnt <= wait_cnt;
      endcase
      if (state == RD_T2 && wait_cnt == '0)
         rdata <= DQ;
   end

   assign ADDR = own      ? addr               : {ADDR_W{1'bz}};
   assign nRD  = own      ? (state != RD_T2)   : 1'bz;
   assign nWR  = own      ? (state != WR_T2)   : 1'bz;
   assign DQ   = wr_phase ? rdata              : {DATA_W{1'bz}};

endmodule

// File: rtl/z80_dma_master.sv
// Z80 DMA bus master: requests the bus, copies a block memory-to-memory, releases it.
// Define Z80_DMA_CYCLE_STEAL_EN to give the bus back for one cycle after every byte.
module z80_dma_master
   import z80_bus_pkg::*;
#(
   parameter int LEN_W   = 16,
   parameter int RD_WAIT = 0,
   parameter int WR_WAIT = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              busy,
   output logic              done,
   output logic              nBUSRQ,
   input  logic              nBUSAK,
   inout  wire               nRD,
   inout  wire               nWR,
   inout  wire  [ADDR_W-1:0] ADDR,
   inout  wire  [DATA_W-1:0] DQ
);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] src;
   logic [ADDR_W-1:0] dst;
   logic [LEN_W-1:0]  count;
   logic              zero_done;
   logic              last_byte;
   logic [ADDR_W-1:0] bus_addr;
   logic              phase_end;
   logic              cycle_done;
   logic [DATA_W-1:0] rdata;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         zero_done <= FALSE;
      end else begin
         state     <= state_nxt;
         zero_done <= (state == IDLE) && start && (length == '0);
      end
   end

   always_ff @(posedge clock) begin
      if (state == IDLE && start) begin
         src   <= src_addr;
         dst   <= dst_addr;
         count <= length;
      end else if (state == WR_T3 && cycle_done) begin
         src   <= src + ADDR_W'(1);
         dst   <= dst + ADDR_W'(1);
         count <= count - LEN_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      last_byte = (count == LEN_W'(1));
      busy      = (state != IDLE);
      done      = (state == REL) || zero_done;
      nBUSRQ    = !(state inside {REQ, RD_T1, RD_T2, RD_T3, WR_T1, WR_T2, WR_T3});
      bus_addr  = (state inside {RD_T1, RD_T2, RD_T3}) ? src : dst;
      case (state)
         IDLE:  if (start && length != '0) state_nxt = REQ;
         REQ:   if (!nBUSAK) state_nxt = RD_T1;
         RD_T1: if (phase_end) state_nxt = RD_T2;
         RD_T2: if (phase_end) state_nxt = RD_T3;
         RD_T3: if (cycle_done) state_nxt = WR_T1;
         WR_T1: if (phase_end) state_nxt = WR_T2;
         WR_T2: if (phase_end) state_nxt = WR_T3;
         WR_T3: begin
            if (cycle_done) begin
               if (last_byte)
                  state_nxt = REL;
`ifdef Z80_DMA_CYCLE_STEAL_EN
               else
                  state_nxt = STEAL;
`else
               else
                  state_nxt = RD_T1;
`endif
            end
         end
         STEAL: state_nxt = REQ;
         REL:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   z80_bus_cycle #(
      .RD_WAIT (RD_WAIT),
      .WR_WAIT (WR_WAIT)
   ) u_cycle (
      .clock      (clock),
      .state      (state),
      .addr       (bus_addr),
      .phase_end  (phase_end),
      .cycle_done (cycle_done),
      .rdata      (rdata),
      .nRD        (nRD),
      .nWR        (nWR),
      .ADDR       (ADDR),
      .DQ         (DQ)
   );

endmodule

// File: tb/tb_z80_dma_master.sv
// Directed bench for z80_dma_master: burst copies, zero length, delayed ack,
// address wrap, wait states (second instance) and reset mid-transfer.
module tb_z80_dma_master;

   logic        clock = 1'b0;
   logic        reset;
   logic        start_a, start_b;
   logic [15:0] src, dst, len;
   logic        busy_a, done_a, nbusrq_a, busy_b, done_b, nbusrq_b;
   logic        nbusak_a = 1'b1;
   logic        nbusak_b;
   logic        ack_block;
   logic        mon_en;
   tri1         nrd_a, nwr_a, nrd_b, nwr_b;
   tri1  [15:0] addr_a, addr_b;
   tri1  [7:0]  dq_a, dq_b;
   logic [7:0]  mem_a [0:65535];
   logic [7:0]  mem_b [0:65535];
   logic        ld_a, ld_b;
   logic [15:0] ld_addr;
   logic [7:0]  ld_data;
   logic [15:0] rd_addrs[$];
   int          rd_lo_b, wr_lo_b;
   int          checks = 0;
   int          errors = 0;

   always #5 clock = ~clock;

   z80_dma_master #(.LEN_W(16), .RD_WAIT(0), .WR_WAIT(0)) dut_a (
      .clock(clock), .reset(reset), .start(start_a), .src_addr(src), .dst_addr(dst),
      .length(len), .busy(busy_a), .done(done_a), .nBUSRQ(nbusrq_a), .nBUSAK(nbusak_a),
      .nRD(nrd_a), .nWR(nwr_a), .ADDR(addr_a), .DQ(dq_a)
   );

   z80_dma_master #(.LEN_W(16), .RD_WAIT(2), .WR_WAIT(1)) dut_b (
      .clock(clock), .reset(reset), .start(start_b), .src_addr(src), .dst_addr(dst),
      .length(len), .busy(busy_b), .done(done_b), .nBUSRQ(nbusrq_b), .nBUSAK(nbusak_b),
      .nRD(nrd_b), .nWR(nwr_b), .ADDR(addr_b), .DQ(dq_b)
   );

   // Arbiter A grants one cycle late unless held off; arbiter B grants immediately.
   always @(posedge clock) nbusak_a <= nbusrq_a | ack_block;
   assign nbusak_b = nbusrq_b;

   assign dq_a = (nrd_a == 1'b0) ? mem_a[addr_a] : 8'hzz;
   assign dq_b = (nrd_b == 1'b0) ? mem_b[addr_b] : 8'hzz;

   always @(posedge clock) begin
      if (ld_a) mem_a[ld_addr] <= ld_data;
      else if (nwr_a == 1'b0) mem_a[addr_a] <= dq_a;
      if (ld_b) mem_b[ld_addr] <= ld_data;
      else if (nwr_b == 1'b0) mem_b[addr_b] <= dq_b;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clock) begin
      if (mon_en) begin
         check("rd_wr_both_low", {30'd0, ~nrd_a & ~nwr_a, ~nrd_b & ~nwr_b}, 32'd0);
         if (nrd_a == 1'b0) rd_addrs.push_back(addr_a);
         if (nrd_b == 1'b0) rd_lo_b++;
         if (nwr_b == 1'b0) wr_lo_b++;
      end
   end

   task automatic poke(input bit which, input logic [15:0] a, input logic [7:0] d);
      ld_addr = a;
      ld_data = d;
      ld_a    = (which == 1'b0);
      ld_b    = (which == 1'b1);
      @(negedge clock);
      ld_a = 1'b0;
      ld_b = 1'b0;
   endtask

   task automatic wait_done(input bit which, inout int n);
      while (n < 200) begin
         @(negedge clock);
         n++;
         if ((which == 1'b0 && done_a) || (which == 1'b1 && done_b)) break;
      end
   endtask

   task automatic run(input bit which, output int n);
      if (which == 1'b0) start_a = 1'b1; else start_b = 1'b1;
      @(posedge clock);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      n = 0;
      wait_done(which, n);
   endtask

   task automatic bus_idle_a(input string tag);
      check({tag, "_ctl"}, {29'd0, nbusrq_a, nrd_a, nwr_a}, 32'h7);
      check({tag, "_addr"}, {16'd0, addr_a}, 32'hFFFF);
      check({tag, "_dq"}, {24'd0, dq_a}, 32'hFF);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      int k;
      int drv;
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0; ack_block = 1'b0;
      ld_a = 1'b0; ld_b = 1'b0; ld_addr = '0; ld_data = '0;
      src = '0; dst = '0; len = '0; mon_en = 1'b0;
      rd_lo_b = 0; wr_lo_b = 0;
      repeat (3) @(negedge clock);
      reset  = 1'b0;
      mon_en = 1'b1;
      @(negedge clock);
      check("reset_busy", {31'd0, busy_a}, 32'd0);
      check("reset_done", {31'd0, done_a}, 32'd0);
      bus_idle_a("reset");

      // Burst copy of three bytes with one-cycle-late ack
      poke(0, 16'h1000, 8'hAA);
      poke(0, 16'h1001, 8'h55);
      poke(0, 16'h1002, 8'hC3);
      src = 16'h1000; dst = 16'h2000; len = 16'd3;
      run(0, n);
      check("t1_latency", n, 32'd21);
      check("t1_busy_in_rel", {31'd0, busy_a}, 32'd1);
      @(negedge clock);
      check("t1_mem0", {24'd0, mem_a[16'h2000]}, 32'hAA);
      check("t1_mem1", {24'd0, mem_a[16'h2001]}, 32'h55);
      check("t1_mem2", {24'd0, mem_a[16'h2002]}, 32'hC3);
      check("t1_busy_after", {31'd0, busy_a}, 32'd0);
      check("t1_done_after", {31'd0, done_a}, 32'd0);
      bus_idle_a("t1_after");

      // Zero length finishes without touching the bus
      len = 16'd0;
      run(0, n);
      check("t2_latency", n, 32'd1);
      check("t2_busy", {31'd0, busy_a}, 32'd0);
      bus_idle_a("t2");
      @(negedge clock);
      check("t2_done_pulse", {31'd0, done_a}, 32'd0);
      check("t2_busrq", {31'd0, nbusrq_a}, 32'd1);

      // Arbiter holds off for ten cycles
      poke(0, 16'h3000, 8'h11);
      poke(0, 16'h3001, 8'h22);
      src = 16'h3000; dst = 16'h4000; len = 16'd2;
      ack_block = 1'b1;
      start_a = 1'b1;
      @(posedge clock);
      #1;
      start_a = 1'b0;
      drv = 0;
      repeat (10) begin
         @(negedge clock);
         if (addr_a !== 16'hFFFF || nrd_a !== 1'b1 || nwr_a !== 1'b1) drv++;
      end
      check("t3_bus_z_before_ack", drv, 32'd0);
      check("t3_busy", {31'd0, busy_a}, 32'd1);
      check("t3_busrq", {31'd0, nbusrq_a}, 32'd0);
      ack_block = 1'b0;
      n = 0;
      wait_done(0, n);
      check("t3_done_seen", {31'd0, done_a}, 32'd1);
      @(negedge clock);
      check("t3_mem0", {24'd0, mem_a[16'h4000]}, 32'h11);
      check("t3_mem1", {24'd0, mem_a[16'h4001]}, 32'h22);

      // Source address wraps from 0xFFFF to 0x0000
      poke(0, 16'hFFFF, 8'h9A);
      poke(0, 16'h0000, 8'h3C);
      src = 16'hFFFF; dst = 16'h5000; len = 16'd2;
      rd_addrs.delete();
      run(0, n);
      check("t4_latency", n, 32'd15);
      check("t4_nreads", rd_addrs.size(), 32'd2);
      check("t4_rd0", {16'd0, (rd_addrs.size() > 0) ? rd_addrs[0] : 16'h1234}, 32'hFFFF);
      check("t4_rd1", {16'd0, (rd_addrs.size() > 1) ? rd_addrs[1] : 16'h1234}, 32'h0000);
      @(negedge clock);
      check("t4_mem0", {24'd0, mem_a[16'h5000]}, 32'h9A);
      check("t4_mem1", {24'd0, mem_a[16'h5001]}, 32'h3C);

      // Wait states on instance B (RD_WAIT=2, WR_WAIT=1), immediate ack
      poke(1, 16'h0100, 8'h7E);
      src = 16'h0100; dst = 16'h0200; len = 16'd1;
      rd_lo_b = 0;
      wr_lo_b = 0;
      run(1, n);
      check("t5_latency", n, 32'd11);
      check("t5_nrd_low_cycles", rd_lo_b, 32'd3);
      check("t5_nwr_low_cycles", wr_lo_b, 32'd2);
      @(negedge clock);
      check("t5_mem", {24'd0, mem_b[16'h0200]}, 32'h7E);

      // Reset during WR_T2 of the second byte
      src = 16'h1000; dst = 16'h6000; len = 16'd3;
      start_a = 1'b1;
      @(posedge clock);
      #1;
      start_a = 1'b0;
      k = 0;
      n = 0;
      while (k < 2 && n < 200) begin
         @(negedge clock);
         n++;
         if (nwr_a == 1'b0) k++;
      end
      check("t6_reach_wr2", k, 32'd2);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      bus_idle_a("t6_rst");
      check("t6_busy", {31'd0, busy_a}, 32'd0);
      check("t6_done", {31'd0, done_a}, 32'd0);
      drv = 0;
      repeat (3) begin
         @(negedge clock);
         if (done_a !== 1'b0 || busy_a !== 1'b0) drv++;
      end
      check("t6_quiet_after_rst", drv, 32'd0);
      src = 16'h1000; dst = 16'h7000; len = 16'd1;
      run(0, n);
      check("t6_restart_latency", n, 32'd9);
      @(negedge clock);
      check("t6_restart_mem", {24'd0, mem_a[16'h7000]}, 32'hAA);
      bus_idle_a("t6_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
